i2c_fifo: RTL

Synchronous single-clock FIFO that buffers 32-bit words between the APB slave and the I2C core. One instance sits on the TX path: the APB side pushes with `WR_ENA`/`WRITE_DATA_ON_TX` and the core pops. A second instance sits on the RX path: the core pushes and the APB side pops with `RD_ENA` into `READ_DATA_ON_RX`. Its `EMPTY` output drives the `TX_EMPTY`/`RX_EMPTY` interrupt inputs of the APB slave.

---
 rtl/i2c_fifo_pkg.sv | 25 ++
 rtl/i2c_fifo_if.sv | 47 ++++
 rtl/i2c_fifo_edge.sv | 22 ++
 rtl/i2c_fifo.sv | 104 ++++++++++
 4 files changed

// File: rtl/i2c_fifo_pkg.sv
// Shared widths, register offsets and helpers for the I2C TX/RX FIFOs.
// Optional sticky error flags are enabled with I2C_FIFO_ERR_EN.
package i2c_fifo_pkg;

  localparam int I2C_FIFO_DWIDTH = 32;
  localparam int I2C_FIFO_AWIDTH = 4;

  localparam logic [7:0] I2C_FIFO_TX_OFS = 8'h00;
  localparam logic [7:0] I2C_FIFO_RX_OFS = 8'h04;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(
    input logic push,
    input logic pop
  );
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/i2c_fifo_if.sv
// Push/pop bundle between an APB-side or core-side user and an i2c_fifo.
// OVERFLOW/UNDERFLOW/ERR_CLR are live only with I2C_FIFO_ERR_EN.
interface i2c_fifo_if
  import i2c_fifo_pkg::*;
#(
  parameter int DWIDTH = I2C_FIFO_DWIDTH,
  parameter int AWIDTH = I2C_FIFO_AWIDTH
) ();

  logic              WR_ENA;
  logic [DWIDTH-1:0] WDATA;
  logic              RD_ENA;
  logic [DWIDTH-1:0] RDATA;
  logic              FULL;
  logic              EMPTY;
  logic [AWIDTH:0]   COUNT;
  logic              OVERFLOW;
  logic              UNDERFLOW;
  logic              ERR_CLR;

  modport master (
    output WR_ENA,
    output WDATA,
    output RD_ENA,
    output ERR_CLR,
    input  RDATA,
    input  FULL,
    input  EMPTY,
    input  COUNT,
    input  OVERFLOW,
    input  UNDERFLOW
  );

  modport slave (
    input  WR_ENA,
    input  WDATA,
    input  RD_ENA,
    input  ERR_CLR,
    output RDATA,
    output FULL,
    output EMPTY,
    output COUNT,
    output OVERFLOW,
    output UNDERFLOW
  );

endinterface

// File: rtl/i2c_fifo_edge.sv
// Rising-edge qualifier for a level request held across APB wait states.
// Build option I2C_FIFO_ERR_EN does not affect this block.
module i2c_fifo_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign rise = d & ~q;

endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through 32-bit FIFO between APB slave and I2C core.
// Define I2C_FIFO_ERR_EN for sticky OVERFLOW/UNDERFLOW flags.
module i2c_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int DWIDTH = I2C_FIFO_DWIDTH,
  parameter int AWIDTH = I2C_FIFO_AWIDTH
) (
  input logic        PCLK,
  input logic        PRESET,
  i2c_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count;

  logic push_req;
  logic pop_req;
  logic push_ok;
  logic pop_ok;
  logic full;
  logic empty;

  i2c_fifo_edge u_wr_edge (
    .clk  (PCLK),
    .rst  (PRESET),
    .d    (bus.WR_ENA),
    .rise (push_req)
  );

  i2c_fifo_edge u_rd_edge (
    .clk  (PCLK),
    .rst  (PRESET),
    .d    (bus.RD_ENA),
    .rise (pop_req)
  );

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees the slot, so push into a full FIFO is legal alongside it.
  assign push_ok = push_req & (~full | pop_req);
  assign pop_ok  = pop_req & ~empty;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case (fifo_op(push_ok, pop_ok))
        FIFO_PUSH: count <= count + 1'b1;
        FIFO_POP:  count <= count - 1'b1;
        default:   count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push_ok && !PRESET) begin
      mem[wr_ptr] <= bus.WDATA;
    end
  end

  assign bus.RDATA = empty ? '0 : mem[rd_ptr];
  assign bus.FULL  = full;
  assign bus.EMPTY = empty;
  assign bus.COUNT = count;

`ifdef I2C_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Set wins over a same-edge clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (push_req & ~push_ok)
             | (ovf_q & ~bus.ERR_CLR);
      unf_q <= (pop_req & ~pop_ok)
             | (unf_q & ~bus.ERR_CLR);
    end
  end

  assign bus.OVERFLOW  = ovf_q;
  assign bus.UNDERFLOW = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.ERR_CLR;

  assign bus.OVERFLOW  = 1'b0;
  assign bus.UNDERFLOW = 1'b0;
`endif

endmodule
